div_iter: RTL and testbench

//  Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/div_step.sv | 31 +++
 rtl/div_iter.sv | 192 +++++++++++++++++++
 tb/tb_div_iter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Holds the divide opcode and FSM state encodings plus small sign helpers.
package mdu_pkg;

   localparam int XLEN  = 64;
   localparam int WLEN  = 32;
   localparam int CNT_W = 7;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // Sign-extend a word result to the full register width.
   function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
      return {{(XLEN-WLEN){v[WLEN-1]}}, v};
   endfunction

   // DIV and REM treat their operands as two's complement.
   function automatic logic op_is_signed(input div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // REM and REMU return the remainder instead of the quotient.
   function automatic logic op_is_rem(input div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// The partial remainder takes in the next dividend bit from the top of quo,
// and the new quotient bit is shifted into the bottom of quo.
module div_step
   import mdu_pkg::*;
(
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] dvs,
   output logic [XLEN-1:0] next_rem,
   output logic [XLEN-1:0] next_quo
);

   // The shifted remainder can reach 2*dvs-1, so it needs one extra bit.
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem, quo[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs};

   // Subtract the divisor when it fits, otherwise restore (keep) the shifted value.
   always_comb begin
      next_rem = shifted[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b0};
      if (shifted >= {1'b0, dvs}) begin
         next_rem = diff[XLEN-1:0];
         next_quo = {quo[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Runs 64 steps (32 for W ops) on operand magnitudes, then applies a sign
// and special-case fixup in one extra cycle before presenting the result.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow skip the iteration and respond one cycle after accept.
module div_iter
   import mdu_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic            req_word,
   input  logic [XLEN-1:0] req_src1,
   input  logic [XLEN-1:0] req_src2,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic [1:0]      dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // req_ready is high only in IDLE; resp_valid stays high with resp_result
   // frozen until resp_ready is seen, and only flush or reset drops it early.
   // flush beats any handshake on the same edge.

   div_state_e       state;
   logic [CNT_W-1:0] counter;
   div_op_e          op_q;
   logic             word_q;
   logic             qsign_q;
   logic             rsign_q;
   logic             dz_q;
   logic             ovf_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvs_q;
   logic [XLEN-1:0]  dividend_q;

   logic [XLEN-1:0]  step_rem;
   logic [XLEN-1:0]  step_quo;

   div_op_e          acc_op;
   logic             acc_signed;
   logic [XLEN-1:0]  acc_a;
   logic [XLEN-1:0]  acc_b;
   logic             acc_s1;
   logic             acc_s2;
   logic [XLEN-1:0]  acc_abs_a;
   logic [XLEN-1:0]  acc_abs_b;
   logic [XLEN-1:0]  acc_min;
   logic             acc_dz;
   logic             acc_ovf;
   logic [XLEN-1:0]  acc_quo;
   logic [CNT_W-1:0] acc_cnt;

   logic [XLEN-1:0]  q_raw;
   logic [XLEN-1:0]  q_val;
   logic [XLEN-1:0]  r_val;
   logic [XLEN-1:0]  fix_sel;
   logic [XLEN-1:0]  fix_result;

   assign dbg_state = state;

   div_step u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dvs      (dvs_q),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   // Operand preparation at accept: width/sign extension, magnitudes, special cases.
   always_comb begin
      acc_op     = div_op_e'(req_op);
      acc_signed = op_is_signed(acc_op);
      acc_a      = req_src1;
      acc_b      = req_src2;
      if (req_word) begin
         acc_a = acc_signed ? sext_word(req_src1[WLEN-1:0])
                            : {{(XLEN-WLEN){1'b0}}, req_src1[WLEN-1:0]};
         acc_b = acc_signed ? sext_word(req_src2[WLEN-1:0])
                            : {{(XLEN-WLEN){1'b0}}, req_src2[WLEN-1:0]};
      end
      acc_s1    = acc_signed & acc_a[XLEN-1];
      acc_s2    = acc_signed & acc_b[XLEN-1];
      acc_abs_a = acc_s1 ? (~acc_a + 1'b1) : acc_a;
      acc_abs_b = acc_s2 ? (~acc_b + 1'b1) : acc_b;
      acc_min   = req_word ? sext_word({1'b1, {(WLEN-1){1'b0}}})
                           : {1'b1, {(XLEN-1){1'b0}}};
      acc_dz    = (acc_b == '0);
      acc_ovf   = acc_signed && (acc_a == acc_min) && (acc_b == '1);
      // A W-op magnitude fits in 32 bits; park it at the top so the
      // first step consumes its most significant bit.
      acc_quo   = req_word ? (acc_abs_a << WLEN) : acc_abs_a;
      acc_cnt   = req_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
`ifdef DIV_FAST_SPECIAL_EN
      if (acc_dz || acc_ovf) begin
         acc_cnt = '0;
      end
`else
`endif
   end

   // Fixup: restore signs, force architectural results for the special cases.
   always_comb begin
      q_raw = word_q ? {{(XLEN-WLEN){1'b0}}, quo_q[WLEN-1:0]} : quo_q;
      q_val = qsign_q ? (~q_raw + 1'b1) : q_raw;
      r_val = rsign_q ? (~rem_q + 1'b1) : rem_q;
      if (dz_q) begin
         q_val = '1;
         r_val = dividend_q;
      end else if (ovf_q) begin
         q_val = dividend_q;
         r_val = '0;
      end
      fix_sel    = op_is_rem(op_q) ? r_val : q_val;
      fix_result = word_q ? sext_word(fix_sel[WLEN-1:0]) : fix_sel;
   end

   // Control FSM with the iteration datapath and registered handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         counter     <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_result <= '0;
         op_q        <= OP_DIV;
         word_q      <= 1'b0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dividend_q  <= '0;
      end else if (flush) begin
         state      <= S_IDLE;
         counter    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  state      <= S_CALC;
                  req_ready  <= 1'b0;
                  counter    <= acc_cnt;
                  op_q       <= acc_op;
                  word_q     <= req_word;
                  qsign_q    <= acc_s1 ^ acc_s2;
                  rsign_q    <= acc_s1;
                  dz_q       <= acc_dz;
                  ovf_q      <= acc_ovf;
                  rem_q      <= '0;
                  quo_q      <= acc_quo;
                  dvs_q      <= acc_abs_b;
                  dividend_q <= acc_a;
               end
            end
            S_CALC: begin
               if (counter != '0) begin
                  rem_q   <= step_rem;
                  quo_q   <= step_quo;
                  counter <= counter - CNT_W'(1);
               end else begin
                  resp_result <= fix_result;
                  resp_valid  <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, randomized ops
// against an arithmetic reference model, backpressure, flush and reset cases.
module tb_div_iter;
   import mdu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_word;
   logic [63:0] req_src1;
   logic [63:0] req_src2;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_result;
   logic [1:0]  dbg_state;

`ifdef DIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   typedef struct {
      logic [1:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   div_iter dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_word    (req_word),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // RISC-V M-extension semantics using native integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
      logic              sgn;
      logic              is_rem;
      int                sa, sb, sq, sr, min_i;
      int unsigned       ua, ub, uq, ur;
      longint            la, lb, lq, lr, min_l;
      longint unsigned   xa, xb, xq, xr;
      logic [31:0]       r32;
      logic [63:0]       r64;
      sgn    = (op == 2'd0) || (op == 2'd2);
      is_rem = (op == 2'd2) || (op == 2'd3);
      if (word) begin
         if (sgn) begin
            sa = a[31:0];
            sb = b[31:0];
            min_i = 32'h8000_0000;
            if (sb == 0) begin
               sq = -1; sr = sa;
            end else if (sa == min_i && sb == -1) begin
               sq = sa; sr = 0;
            end else begin
               sq = sa / sb; sr = sa % sb;
            end
            r32 = is_rem ? sr : sq;
         end else begin
            ua = a[31:0];
            ub = b[31:0];
            if (ub == 0) begin
               uq = 32'hFFFF_FFFF; ur = ua;
            end else begin
               uq = ua / ub; ur = ua % ub;
            end
            r32 = is_rem ? ur : uq;
         end
         return {{32{r32[31]}}, r32};
      end
      if (sgn) begin
         la = a;
         lb = b;
         min_l = 64'h8000_0000_0000_0000;
         if (lb == 0) begin
            lq = -1; lr = la;
         end else if (la == min_l && lb == -1) begin
            lq = la; lr = 0;
         end else begin
            lq = la / lb; lr = la % lb;
         end
         r64 = is_rem ? lr : lq;
      end else begin
         xa = a;
         xb = b;
         if (xb == 0) begin
            xq = 64'hFFFF_FFFF_FFFF_FFFF; xr = xa;
         end else begin
            xq = xa / xb; xr = xa % xb;
         end
         r64 = is_rem ? xr : xq;
      end
      return r64;
   endfunction

   // Cycles from the accept edge to the first edge showing resp_valid.
   function automatic int ref_latency(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
      logic sgn;
      logic special;
      sgn = (op == 2'd0) || (op == 2'd2);
      if (word)
         special = (b[31:0] == 32'd0) ||
                   (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else
         special = (b == 64'd0) ||
                   (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
      if (FAST && special) return 1;
      return word ? 33 : 65;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic add_vec(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
      vec_t v;
      v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Present a request once req_ready is seen; returns after the accept edge.
   task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b);
      int waited;
      waited = 0;
      while (!req_ready && waited < 200) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      req_valid = 1'b1;
      req_op    = op;
      req_word  = word;
      req_src1  = a;
      req_src2  = b;
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Count edges until resp_valid; -1 means it never came.
   task automatic wait_resp(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clock); #1;
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
      issue(op, word, a, b);
      wait_resp(lat);
      res = resp_result;
      if (lat > 0) take_resp();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [63:0] res;
      logic [63:0] exp;
      logic [63:0] a, b;
      logic [1:0]  op;
      logic        word;
      int          lat;
      int          seen;
      int          sel;

      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
      req_src1 = '0; req_src2 = '0; resp_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_int("reset_req_ready", int'(req_ready), 1);
      check_int("reset_resp_valid", int'(resp_valid), 0);
      check64("reset_resp_result", resp_result, 64'd0);
      check_int("reset_state", int'(dbg_state), 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Directed vector table.
      add_vec(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
      add_vec(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
      add_vec(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5);
      add_vec(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999);
      add_vec(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
      add_vec(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      add_vec(2'd0, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      add_vec(2'd2, 1'b0, 64'd7, 64'd0, 64'd7);
      add_vec(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      add_vec(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9);
      add_vec(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
      add_vec(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      add_vec(2'd1, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF);
      add_vec(2'd3, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      add_vec(2'd0, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      add_vec(2'd2, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
      add_vec(2'd1, 1'b0, 64'd100, 64'd7, 64'd14);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, res, lat);
         check64($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check_int($sformatf("vec%0d_latency", i), lat,
                   ref_latency(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b));
      end

      // Randomized ops against the reference model via the expected queue.
      for (int n = 0; n < 30; n++) begin
         op   = 2'($urandom_range(0, 3));
         word = 1'($urandom_range(0, 1));
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom} >> $urandom_range(0, 63);
         sel  = $urandom_range(0, 9);
         if (sel == 0) b = 64'd0;
         else if (sel == 1) begin
            b = 64'hFFFF_FFFF_FFFF_FFFF;
            a = word ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
         end else if (sel == 2) b = 64'($urandom_range(1, 15));
         else if (sel == 3) a = -a;
         exp_q.push_back(ref_result(op, word, a, b));
         run_op(op, word, a, b, res, lat);
         exp = exp_q.pop_front();
         check64($sformatf("rand%0d_op%0d_w%0d_result", n, op, word), res, exp);
         check_int($sformatf("rand%0d_latency", n), lat, ref_latency(op, word, a, b));
      end

      // Backpressure: result held, no new request accepted while waiting.
      issue(2'd1, 1'b0, 64'd1000, 64'd3);
      wait_resp(lat);
      check_int("bp_latency", lat, 65);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check_int($sformatf("bp_hold%0d_valid", i), int'(resp_valid), 1);
         check64($sformatf("bp_hold%0d_result", i), resp_result, 64'd333);
         check_int($sformatf("bp_hold%0d_req_ready", i), int'(req_ready), 0);
      end
      take_resp();
      check_int("bp_release_valid", int'(resp_valid), 0);
      check_int("bp_release_req_ready", int'(req_ready), 1);
      // Back-to-back issue the cycle right after returning to IDLE.
      req_valid = 1'b1; req_op = 2'd0; req_word = 1'b0;
      req_src1 = 64'd100; req_src2 = 64'hFFFF_FFFF_FFFF_FFF9;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check_int("b2b_accepted_state", int'(dbg_state), 1);
      check_int("b2b_req_ready", int'(req_ready), 0);
      wait_resp(lat);
      check_int("b2b_latency", lat, 65);
      check64("b2b_result", resp_result, 64'hFFFF_FFFF_FFFF_FFF2);
      if (lat > 0) take_resp();

      // Flush at step 20.
      issue(2'd1, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'd12345);
      repeat (20) @(posedge clock);
      #1;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check_int("flush_state", int'(dbg_state), 0);
      check_int("flush_req_ready", int'(req_ready), 1);
      check_int("flush_resp_valid", int'(resp_valid), 0);

      // Asynchronous reset at step 5 of a new op.
      issue(2'd0, 1'b0, 64'd987654321, 64'd3);
      repeat (5) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_int("areset_state", int'(dbg_state), 0);
      check_int("areset_req_ready", int'(req_ready), 1);
      check_int("areset_resp_valid", int'(resp_valid), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clock); #1;
         if (resp_valid) seen++;
      end
      check_int("after_kill_no_resp", seen, 0);
      check_int("after_kill_req_ready", int'(req_ready), 1);
      run_op(2'd1, 1'b0, 64'd100, 64'd7, res, lat);
      check64("after_kill_divu_result", res, 64'd14);
      check_int("after_kill_divu_latency", lat, 65);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
